// File: rtl/lq_stq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lq_stq_pkg
// Description : Shared size encodings, FSM state type and helpers for the
//               store-data align path.
// Revision    : 1.0 - initial release
// ============================================================================
package lq_stq_pkg;

    localparam logic [1:0] SZ_1B = 2'b00;
    localparam logic [1:0] SZ_2B = 2'b01;
    localparam logic [1:0] SZ_4B = 2'b10;
    localparam logic [1:0] SZ_8B = 2'b11;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SPLIT = 1'b1
    } stq_state_t;

    function automatic logic [3:0] size_bytes(input logic [1:0] sz);
        case (sz)
            SZ_1B: size_bytes = 4'd1;
            SZ_2B: size_bytes = 4'd2;
            SZ_4B: size_bytes = 4'd4;
            SZ_8B: size_bytes = 4'd8;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/lq_stq_rotl64.sv
`default_nettype none
// ============================================================================
// Module      : lq_stq_rotl64
// Description : Byte rotate-left of a big-endian doubleword plus byte-enable
//               generation for the first or second beat of a store.
// Revision    : 1.0 - initial release
// ============================================================================
module lq_stq_rotl64 (
    input  logic [0:63] i_data,
    input  logic [2:0]  i_rot,
    input  logic [2:0]  i_a,
    input  logic [3:0]  i_e,
    input  logic        i_beat,
    output logic [0:63] o_data,
    output logic [0:7]  o_be
);

    always_comb begin
        o_data = '0;
        o_be   = '0;
        for (int j = 0; j < 8; j++) begin
            // Output lane j takes source byte (j + rot) mod 8.
            o_data[8*j +: 8] = i_data[8*((j + int'(i_rot)) & 7) +: 8];
            if (i_beat) begin
                o_be[j] = (5'(j) + 5'd8) < {1'b0, i_e};
            end else begin
                o_be[j] = (4'(j) >= {1'b0, i_a}) && (4'(j) < i_e);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/lq_stq_data_align.sv
`default_nettype none
// ============================================================================
// Module      : lq_stq_data_align
// Description : Rotates right-justified store data into doubleword byte lanes,
//               builds byte enables and splits DW-crossing stores into two
//               beats. Option macro: LQ_STQ_BYTE_REV_EN (byte-reversed stores).
// Revision    : 1.0 - initial release
// ============================================================================
module lq_stq_data_align
    import lq_stq_pkg::*;
#(
    parameter int ADDR_WIDTH = 64,
    parameter int ITAG_WIDTH = 7
) (
    input  logic                    clk,
    input  logic                    rst_b,
    input  logic                    ex_st_val,
    output logic                    ex_st_rdy,
    input  logic [64-ADDR_WIDTH:63] ex_st_addr,
    input  logic [1:0]              ex_st_size,
    input  logic [0:63]             ex_st_data,
    input  logic [ITAG_WIDTH-1:0]   ex_st_itag,
`ifdef LQ_STQ_BYTE_REV_EN
    input  logic                    ex_st_byte_rev,
`endif
    output logic                    st_out_val,
    input  logic                    st_out_rdy,
    output logic [64-ADDR_WIDTH:63] st_out_addr,
    output logic [0:63]             st_out_data,
    output logic [0:7]              st_out_be,
    output logic                    st_out_last,
    output logic [ITAG_WIDTH-1:0]   st_out_itag
);

    stq_state_t              r_state;
    stq_state_t              w_next;
    logic                    r_val;
    logic [64-ADDR_WIDTH:63] r_addr;
    logic [0:63]             r_data;
    logic [0:7]              r_be;
    logic                    r_last;
    logic [ITAG_WIDTH-1:0]   r_itag;
    logic [3:0]              r_e;

    logic [2:0]  w_a;
    logic [3:0]  w_nbytes;
    logic [3:0]  w_e;
    logic [2:0]  w_rot;
    logic [0:63] w_src;
    logic [0:63] w_rot_data;
    logic [0:7]  w_be;
    logic        w_beat;
    logic [3:0]  w_be_e;
    logic        w_hs;
    logic        w_rdy;
    logic        w_load0;
    logic        w_load1;
    logic        w_drain;

    assign w_a      = ex_st_addr[61:63];
    assign w_nbytes = size_bytes(ex_st_size);
    assign w_e      = {1'b0, w_a} + w_nbytes;
    assign w_rot    = 3'(4'd8 - w_e);

`ifdef LQ_STQ_BYTE_REV_EN
    // Reverse only the live low bytes (8-S..7); upper bytes pass through.
    always_comb begin
        w_src = ex_st_data;
        if (ex_st_byte_rev) begin
            for (int k = 0; k < 8; k++) begin
                if (k >= 8 - int'(w_nbytes)) begin
                    w_src[8*k +: 8] = ex_st_data[8*(15 - int'(w_nbytes) - k) +: 8];
                end
            end
        end
    end
`else
    assign w_src = ex_st_data;
`endif

    // In SPLIT the rotator only supplies beat-1 enables from the saved end offset.
    assign w_beat = (r_state == SPLIT);
    assign w_be_e = w_beat ? r_e : w_e;

    lq_stq_rotl64 u_rotl (
        .i_data (w_src),
        .i_rot  (w_rot),
        .i_a    (w_a),
        .i_e    (w_be_e),
        .i_beat (w_beat),
        .o_data (w_rot_data),
        .o_be   (w_be)
    );

    assign w_hs = r_val & st_out_rdy;

    always_comb begin
        w_next  = r_state;
        w_rdy   = 1'b0;
        w_load0 = 1'b0;
        w_load1 = 1'b0;
        w_drain = 1'b0;
        case (r_state)
            IDLE: begin
                w_rdy = ~r_val | st_out_rdy;
                if (ex_st_val && w_rdy) begin
                    w_load0 = 1'b1;
                    if (w_e > 4'd8) begin
                        w_next = SPLIT;
                    end
                end else if (w_hs) begin
                    w_drain = 1'b1;
                end
            end
            SPLIT: begin
                if (w_hs) begin
                    w_load1 = 1'b1;
                    w_next  = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_val  <= 1'b0;
            r_addr <= '0;
            r_data <= '0;
            r_be   <= '0;
            r_last <= 1'b0;
            r_itag <= '0;
            r_e    <= '0;
        end else if (w_load0) begin
            r_val  <= 1'b1;
            r_addr <= {ex_st_addr[64-ADDR_WIDTH:60], 3'b000};
            r_data <= w_rot_data;
            r_be   <= w_be;
            r_last <= (w_e <= 4'd8);
            r_itag <= ex_st_itag;
            r_e    <= w_e;
        end else if (w_load1) begin
            r_addr <= r_addr + ADDR_WIDTH'(8);
            r_be   <= w_be;
            r_last <= 1'b1;
        end else if (w_drain) begin
            r_val  <= 1'b0;
        end
    end

    assign ex_st_rdy   = w_rdy;
    assign st_out_val  = r_val;
    assign st_out_addr = r_addr;
    assign st_out_data = r_data;
    assign st_out_be   = r_be;
    assign st_out_last = r_last;
    assign st_out_itag = r_itag;

endmodule
`default_nettype wire

// File: tb/tb_lq_stq_data_align.sv
`default_nettype none
// ============================================================================
// Module      : tb_lq_stq_data_align
// Description : Directed vector table, multi-cycle corner sequences and random
//               stores checked against a byte-placement reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lq_stq_data_align;

    localparam int IW = 7;

    logic          clk = 1'b0;
    logic          rst_b = 1'b0;
    logic          ex_st_val = 1'b0;
    logic          ex_st_rdy;
    logic [0:63]   ex_st_addr = '0;
    logic [1:0]    ex_st_size = '0;
    logic [0:63]   ex_st_data = '0;
    logic [IW-1:0] ex_st_itag = '0;
`ifdef LQ_STQ_BYTE_REV_EN
    logic          ex_st_byte_rev = 1'b0;
`endif
    logic          st_out_val;
    logic          st_out_rdy = 1'b0;
    logic [0:63]   st_out_addr;
    logic [0:63]   st_out_data;
    logic [0:7]    st_out_be;
    logic          st_out_last;
    logic [IW-1:0] st_out_itag;

    always #5 clk = ~clk;

    lq_stq_data_align #(.ADDR_WIDTH(64), .ITAG_WIDTH(IW)) dut (
        .clk            (clk),
        .rst_b          (rst_b),
        .ex_st_val      (ex_st_val),
        .ex_st_rdy      (ex_st_rdy),
        .ex_st_addr     (ex_st_addr),
        .ex_st_size     (ex_st_size),
        .ex_st_data     (ex_st_data),
        .ex_st_itag     (ex_st_itag),
`ifdef LQ_STQ_BYTE_REV_EN
        .ex_st_byte_rev (ex_st_byte_rev),
`endif
        .st_out_val     (st_out_val),
        .st_out_rdy     (st_out_rdy),
        .st_out_addr    (st_out_addr),
        .st_out_data    (st_out_data),
        .st_out_be      (st_out_be),
        .st_out_last    (st_out_last),
        .st_out_itag    (st_out_itag)
    );

    typedef struct {
        logic [0:63]   addr;
        logic [0:63]   data;
        logic [0:7]    be;
        logic          last;
        logic [IW-1:0] itag;
    } beat_t;

    typedef struct {
        logic [1:0]  size;
        logic [0:63] addr;
        logic [0:63] data;
        logic        rev;
        logic [0:63] exp_data;
        logic [0:7]  be0;
        logic [0:7]  be1;
        logic        split;
    } vec_t;

    beat_t exp_q[$];
    vec_t  vt[$];
    int    n_vec = 0;
    int    n_bad = 0;
    bit    rdy_rand = 1'b0;

    function automatic void cmp(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endfunction

    function automatic logic [143:0] pack(input beat_t b);
        return {b.addr, b.data, b.be, b.last, b.itag};
    endfunction

    // Reference: store byte k lands at memory address A+k; the full lane image
    // wraps the remaining source bytes around the doubleword.
    function automatic void model_push(input logic [1:0] sz, input logic [0:63] ad,
                                       input logic [0:63] d, input logic rev,
                                       input logic [IW-1:0] tag);
        int          s;
        int          a;
        logic [7:0]  src [8];
        beat_t       b0;
        beat_t       b1;
        s = 1 << sz;
        a = int'(ad[61:63]);
        for (int i = 0; i < 8; i++) src[i] = d[8*i +: 8];
        if (rev) for (int k = 0; k < s; k++) src[8-s+k] = d[8*(7-k) +: 8];
        b0.addr = ad & ~64'h7;
        b0.data = '0;
        b0.be   = '0;
        b1.be   = '0;
        for (int k = 0; k < 8; k++) b0.data[8*((a+k)%8) +: 8] = src[(8-s+k)%8];
        for (int k = 0; k < s; k++) begin
            if (a + k < 8) b0.be[a+k] = 1'b1;
            else           b1.be[a+k-8] = 1'b1;
        end
        b0.last = (a + s <= 8);
        b0.itag = tag;
        exp_q.push_back(b0);
        if (!b0.last) begin
            b1.addr = b0.addr + 64'd8;
            b1.data = b0.data;
            b1.last = 1'b1;
            b1.itag = tag;
            exp_q.push_back(b1);
        end
    endfunction

    task automatic add_vec(input logic [1:0] sz, input logic [0:63] ad, input logic [0:63] d,
                           input logic rev, input logic [0:63] ed, input logic [0:7] be0,
                           input logic [0:7] be1, input logic split);
        vec_t v;
        v.size = sz; v.addr = ad; v.data = d; v.rev = rev;
        v.exp_data = ed; v.be0 = be0; v.be1 = be1; v.split = split;
        vt.push_back(v);
    endtask

    // Call at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic send(input logic [1:0] sz, input logic [0:63] ad, input logic [0:63] d,
                        input logic rev, input logic [IW-1:0] tag);
        bit ok;
        ex_st_val  = 1'b1;
        ex_st_size = sz;
        ex_st_addr = ad;
        ex_st_data = d;
        ex_st_itag = tag;
`ifdef LQ_STQ_BYTE_REV_EN
        ex_st_byte_rev = rev;
`else
        if (rev) $display("note: byte-reverse request ignored in this build");
`endif
        ok = 1'b0;
        for (int c = 0; c < 64; c++) begin
            @(negedge clk);
            if (ex_st_rdy) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        ex_st_val  = 1'b0;
        ex_st_addr = {$urandom, $urandom};
        ex_st_data = {$urandom, $urandom};
        ex_st_size = 2'($urandom);
        if (!ok) cmp("accept_timeout", 0, 1);
    endtask

    task automatic drain(input string nm);
        for (int c = 0; c < 100; c++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        cmp(nm, exp_q.size(), 0);
    endtask

    initial begin : g_rdy_rand
        forever begin
            @(posedge clk);
            #1;
            if (rdy_rand) st_out_rdy = ($urandom % 4) != 0;
        end
    end

    // Output monitor: scoreboard pop on handshake and hold check while stalled.
    initial begin : g_monitor
        logic [143:0] cur;
        logic [143:0] prev;
        bit           prev_stall;
        beat_t        e;
        prev_stall = 1'b0;
        prev = '0;
        forever begin
            @(negedge clk);
            if (!rst_b) begin
                prev_stall = 1'b0;
            end else begin
                cur = {st_out_addr, st_out_data, st_out_be, st_out_last, st_out_itag};
                if (prev_stall) cmp("stall_hold", {st_out_val, cur}, {1'b1, prev});
                if (st_out_val && st_out_rdy) begin
                    if (exp_q.size() == 0) begin
                        cmp("unexpected_beat", {1'b1, cur}, 0);
                    end else begin
                        e = exp_q.pop_front();
                        cmp("beat", cur, pack(e));
                    end
                end
                prev_stall = st_out_val && !st_out_rdy;
                prev = cur;
            end
        end
    end

    initial begin : g_watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin : g_main
        vec_t        v;
        beat_t       b;
        logic [1:0]  sz;
        logic [0:63] ad;
        logic        rev;

        add_vec(2'b11, 64'h1000, 64'h0011223344556677, 1'b0, 64'h0011223344556677, 8'hFF, 8'h00, 1'b0);
        add_vec(2'b00, 64'h2003, 64'h00000000000000AB, 1'b0, 64'h000000AB00000000, 8'h10, 8'h00, 1'b0);
        add_vec(2'b10, 64'h3006, 64'h00000000DEADBEEF, 1'b0, 64'hBEEF00000000DEAD, 8'h03, 8'hC0, 1'b1);
        add_vec(2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1234, 1'b0, 64'h3400000000000012, 8'h01, 8'h80, 1'b1);
        add_vec(2'b01, 64'h10, 64'hAABBCCDDEEFF1234, 1'b0, 64'h1234AABBCCDDEEFF, 8'hC0, 8'h00, 1'b0);
        add_vec(2'b11, 64'h6001, 64'h0011223344556677, 1'b0, 64'h7700112233445566, 8'h7F, 8'h80, 1'b1);
`ifdef LQ_STQ_BYTE_REV_EN
        add_vec(2'b01, 64'h7000, 64'h1234, 1'b1, 64'h3412000000000000, 8'hC0, 8'h00, 1'b0);
`endif

        repeat (3) @(posedge clk);
        #1;
        cmp("reset_outputs", {st_out_val, st_out_addr, st_out_data, st_out_be, st_out_last, st_out_itag}, 0);
        rst_b = 1'b1;
        @(negedge clk);
        cmp("reset_rdy", ex_st_rdy, 1);

        // Directed table with the output always ready.
        @(posedge clk);
        #1;
        st_out_rdy = 1'b1;
        for (int i = 0; i < vt.size(); i++) begin
            v = vt[i];
            b.addr = v.addr & ~64'h7;
            b.data = v.exp_data;
            b.be   = v.be0;
            b.last = !v.split;
            b.itag = 7'(i + 1);
            exp_q.push_back(b);
            if (v.split) begin
                b.addr = b.addr + 64'd8;
                b.be   = v.be1;
                b.last = 1'b1;
                exp_q.push_back(b);
            end
            send(v.size, v.addr, v.data, v.rev, 7'(i + 1));
            cmp("latency_val", st_out_val, 1);
            if (v.split) cmp("split_rdy_low", ex_st_rdy, 0);
        end
        drain("directed_drain");

        // Split store stalled three cycles: beat 0 held, no accept, beat 1 on release.
        @(posedge clk);
        #1;
        st_out_rdy = 1'b0;
        model_push(2'b10, 64'h4005, 64'h00000000CAFEF00D, 1'b0, 7'h55);
        send(2'b10, 64'h4005, 64'h00000000CAFEF00D, 1'b0, 7'h55);
        ex_st_val = 1'b1;
        repeat (3) begin
            @(negedge clk);
            cmp("stall_no_accept", ex_st_rdy, 0);
        end
        @(posedge clk);
        #1;
        ex_st_val  = 1'b0;
        st_out_rdy = 1'b1;
        @(posedge clk);
        #1;
        cmp("beat1_after_release", {st_out_val, st_out_last, st_out_be}, {1'b1, 1'b1, 8'h80});
        drain("stall_drain");

        // Reset in the middle of a split discards both beats.
        @(posedge clk);
        #1;
        st_out_rdy = 1'b0;
        send(2'b11, 64'h5003, 64'h0102030405060708, 1'b0, 7'h2A);
        #1;
        rst_b = 1'b0;
        #1;
        cmp("reset_async", {st_out_val, st_out_addr, st_out_data, st_out_be, st_out_last, st_out_itag}, 0);
        @(posedge clk);
        #1;
        rst_b = 1'b1;
        @(negedge clk);
        cmp("reset_rdy_after_split", {ex_st_rdy, st_out_val}, 2'b10);

        // Random stores with random back-pressure.
        @(posedge clk);
        #1;
        rdy_rand = 1'b1;
        for (int n = 0; n < 400; n++) begin
            if ($urandom % 4 == 0) begin
                @(posedge clk);
                #1;
            end
            sz = 2'($urandom);
            ad = {$urandom, $urandom};
            if ($urandom % 8 == 0) ad = 64'hFFFF_FFFF_FFFF_FFF8 | 64'($urandom % 8);
            rev = 1'b0;
`ifdef LQ_STQ_BYTE_REV_EN
            rev = 1'($urandom);
`endif
            v.data = {$urandom, $urandom};
            model_push(sz, ad, v.data, rev, 7'(n));
            send(sz, ad, v.data, rev, 7'(n));
        end
        rdy_rand = 1'b0;
        @(posedge clk);
        #2;
        st_out_rdy = 1'b1;
        drain("final_drain");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lq_stq_data_align.md
Name: lq_stq_data_align

Overview:
Store-side counterpart to the load-data rotate/mask/sign-extend path. It takes right-justified store data from the execution pipe and rotates it into big-endian byte lanes of an 8-byte doubleword, generating byte enables. Stores that cross a doubleword boundary are split into two beats. It sits between the execution pipe and the store queue data write port, with a valid/ready handshake on both sides.

Parameters:
ADDR_WIDTH, 64, effective address width; addresses are [64-ADDR_WIDTH:63].
ITAG_WIDTH, 7, instruction tag width passed through unchanged.

Ports:
clk  input  1  clock
rst_b  input  1  asynchronous active-low reset
ex_st_val  input  1  store request valid
ex_st_rdy  output  1  block accepts the request this cycle
ex_st_addr  input  ADDR_WIDTH  byte effective address
ex_st_size  input  2  00=1B, 01=2B, 10=4B, 11=8B
ex_st_data  input  64  [0:63], right-justified store data (LSB byte = byte 7)
ex_st_itag  input  ITAG_WIDTH  instruction tag
st_out_val  output  1  aligned beat valid
st_out_rdy  input  1  store queue accepts the beat
st_out_addr  output  ADDR_WIDTH  doubleword-aligned address; bits [61:63]=0
st_out_data  output  64  rotated data
st_out_be  output  8  byte enables; be[i] covers data[8i:8i+7]
st_out_last  output  1  final beat of this store
st_out_itag  output  ITAG_WIDTH  tag of the store

Behaviour:
- Terms: S = size in bytes, A = ex_st_addr[61:63], E = A+S (0..15).
- Rotation: data = rotate-left of ex_st_data by ((8-E) mod 8) bytes. Byte i moves to byte (i-rot) mod 8.
- Beat 0: addr = {ex_st_addr[..:60],000}; be[j]=1 for A<=j<=min(E-1,7).
- If E<=8, beat 0 has last=1.
- If E>8 (split), beat 0 has last=0. Beat 1 has addr = beat0 addr + 8, wrapping modulo 2^ADDR_WIDTH. Beat 1 be[j]=1 for 0<=j<=E-9, uses the same rotated data and tag, and has last=1.
- Alignment is not checked. Any size/offset is legal, and an 8B store at A=0 is a single beat with be=FF.
- FSM states: IDLE and SPLIT. A single output register holds val/addr/data/be/last/itag.
  - ex_st_rdy = (state==IDLE) & (~st_out_val | st_out_rdy).
  - IDLE, accept (ex_st_val & ex_st_rdy): load beat 0 into the output register the next cycle (latency 1). Go to SPLIT if E>8, otherwise stay in IDLE.
  - SPLIT: ex_st_rdy=0. When beat 0 handshakes (st_out_val & st_out_rdy), load beat 1 the next edge and go to IDLE.
  - Output handshake with no new load: st_out_val clears.
- Back-to-back: in IDLE, a beat with last=1 handshaking in the same cycle as a new accept is replaced by the new beat with no bubble. Sustained throughput is 1 store/cycle unsplit and 2 cycles per split store.
- Stall: while st_out_val & ~st_out_rdy, all st_out_* outputs are held stable.
- ex_st_* inputs are sampled only on accept. They are don't-care otherwise.
- Reset (async assert, sync deassert externally): state=IDLE; st_out_val, addr, data, be, last and itag are all 0. ex_st_rdy=1 after deassertion. Reset mid-split discards both beats.

Optional Feature:
Macro LQ_STQ_BYTE_REV_EN.
- Defined: adds input ex_st_byte_rev (1). When it is set on accept, the low S bytes of ex_st_data (bytes 8-S..7) are reversed in place before rotation (byte-reversed stores). Byte enables and splitting are unchanged.
- Undefined: the port is absent and no reversal logic is built.

Decomposition:
- Package lq_stq_pkg:
  - size encoding localparams (SZ_1B..SZ_8B)
  - FSM state typedef (IDLE, SPLIT)
  - a size-to-byte-count function
- Sub-module lq_stq_rotl64: combinational byte rotate-left of 64 bits by a 3-bit amount, plus be generation from (A, E, beat). Instantiated once.
- The top level holds the FSM, the output register and address increment.

Test Plan:
- 8B store, addr 0x1000, data 0x0011223344556677, st_out_rdy=1 -> one cycle later val=1, addr 0x1000, data 0x0011223344556677, be=FF, last=1.
- 1B store, addr 0x2003, data 0x...00AB -> rot=4; data byte3=AB, be=10 (binary 0001_0000, byte 3), last=1.
- 4B store, addr 0x3006, data 0x00000000DEADBEEF:
  - beat0: addr 0x3000, data bytes 6,7=DE,AD, be=03, last=0.
  - beat1: addr 0x3008, bytes 0,1=BE,EF, be=C0, last=1.
  - ex_st_rdy stays 0 until beat1 has loaded.
- Split store with st_out_rdy held 0 for 3 cycles -> beat0 stable for all 3 cycles, no beat1 and no new accept. Release rdy -> beat1 on the next cycle.
- Wrap: 2B store, addr 0xFFFF_FFFF_FFFF_FFFF -> beat0 addr 0xFFFF_FFFF_FFFF_FFF8 be=01. Beat1 addr 0x0 be=80.
- Reset asserted during SPLIT -> outputs 0 immediately, ex_st_rdy=1 after release. With LQ_STQ_BYTE_REV_EN: 2B byte-rev store of 0x1234 at offset 0 -> bytes 0,1=34,12.
